// File: rtl/event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : event_arbiter
// Purpose  : Round-robin merge of detector event streams; a time tag is
//            inserted ahead of any event whose period differs from the last.
// Revision : 1.0  initial release
// ============================================================================
module event_arbiter #(
  parameter int NBLOCKS     = 4,
  parameter int DATA_BITS   = 128,
  parameter int PERIOD_BITS = 48
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NBLOCKS-1:0]             enable,
  input  logic [NBLOCKS-1:0]             in_valid,
  output logic [NBLOCKS-1:0]             in_ready,
  input  logic [NBLOCKS*DATA_BITS-1:0]   in_data,
  input  logic [NBLOCKS*PERIOD_BITS-1:0] in_period,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_BITS-1:0]           out_data,
  output logic                           out_is_tag
);

  localparam int IDX_W = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TAG   = 2'd1,
    ST_EVENT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_last_grant;
  logic [DATA_BITS-1:0]   r_data;
  logic [PERIOD_BITS-1:0] r_period;
  logic [PERIOD_BITS-1:0] r_cur_period;
  logic                   r_tag_valid;
  logic                   r_out_valid;
  logic                   r_out_is_tag;
  logic [DATA_BITS-1:0]   r_out_data;

  logic [NBLOCKS-1:0]     w_req;
  logic [NBLOCKS-1:0]     w_pop;
  logic                   w_found;
  logic [IDX_W-1:0]       w_grant_idx;
  logic [IDX_W-1:0]       w_cand;
  logic [DATA_BITS-1:0]   w_win_data;
  logic [PERIOD_BITS-1:0] w_win_period;
  logic                   w_need_tag;

  function automatic logic [DATA_BITS-1:0] make_tag(input logic [PERIOD_BITS-1:0] p);
    make_tag = '0;
    make_tag[DATA_BITS-1 -: 5] = 5'b11111;
    make_tag[PERIOD_BITS-1:0]  = p;
  endfunction

  assign w_req        = in_valid & enable;
  assign w_win_data   = in_data[w_grant_idx*DATA_BITS +: DATA_BITS];
  assign w_win_period = in_period[w_grant_idx*PERIOD_BITS +: PERIOD_BITS];
  assign w_need_tag   = !r_tag_valid || (w_win_period != r_cur_period);

  // Search starts one past the previous winner so every requester is served in turn
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < NBLOCKS; k++) begin
      w_cand = IDX_W'((int'(r_last_grant) + 1 + k) % NBLOCKS);
      if (!w_found && w_req[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_pop[w_grant_idx] = 1'b1;
          w_state_nxt        = w_need_tag ? ST_TAG : ST_EVENT;
        end
      end
      ST_TAG:   if (out_ready) w_state_nxt = ST_EVENT;
      ST_EVENT: if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= IDX_W'(NBLOCKS - 1);
      r_data       <= '0;
      r_period     <= '0;
      r_cur_period <= '0;
      r_tag_valid  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_is_tag <= 1'b0;
      r_out_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_last_grant <= w_grant_idx;
            r_data       <= w_win_data;
            r_period     <= w_win_period;
            r_out_valid  <= 1'b1;
            r_out_is_tag <= w_need_tag;
            r_out_data   <= w_need_tag ? make_tag(w_win_period) : w_win_data;
          end
        end
        ST_TAG: begin
          if (out_ready) begin
            r_cur_period <= r_period;
            r_tag_valid  <= 1'b1;
            r_out_is_tag <= 1'b0;
            r_out_data   <= r_data;
          end
        end
        ST_EVENT: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_out_is_tag <= 1'b0;
          end
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  // The pop strobe is combinational from the grant, so it must be held off during reset
  assign in_ready   = rst ? '0 : w_pop;
  assign out_valid  = r_out_valid;
  assign out_is_tag = r_out_is_tag;
  assign out_data   = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_arbiter
// Purpose  : Directed scoreboard bench for event_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_event_arbiter;

  localparam int NB = 4;
  localparam int DB = 128;
  localparam int PB = 48;

  typedef struct packed {
    logic [PB-1:0] p;
    logic [DB-1:0] d;
  } ev_t;

  logic             clk;
  logic             rst;
  logic [NB-1:0]    enable;
  logic [NB-1:0]    in_valid;
  logic [NB-1:0]    in_ready;
  logic [NB*DB-1:0] in_data;
  logic [NB*PB-1:0] in_period;
  logic             out_valid;
  logic             out_ready;
  logic [DB-1:0]    out_data;
  logic             out_is_tag;

  ev_t          sq[NB][$];
  logic [DB:0]  exp_q[$];
  int           glog[$];
  int           xfer_t[$];
  logic [NB-1:0] pop_mask;
  int           cyc;
  int           n_checks;
  int           n_pass;
  logic         m_tag_valid;
  logic [PB-1:0] m_cur;

  event_arbiter #(.NBLOCKS(NB), .DATA_BITS(DB), .PERIOD_BITS(PB)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_period (in_period),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_is_tag(out_is_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DB-1:0] tag_of(input logic [PB-1:0] p);
    logic [DB-1:0] t;
    t = '0;
    t[DB-1 -: 5] = 5'b11111;
    t[PB-1:0]    = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [DB:0] obs, input logic [DB:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int i, input logic [PB-1:0] p, input logic [DB-1:0] d);
    ev_t e;
    e.p = p;
    e.d = d;
    sq[i].push_back(e);
  endtask

  // Reference: a tag precedes any event whose period differs from the last tagged one
  task automatic exp_event(input logic [PB-1:0] p, input logic [DB-1:0] d);
    if (!m_tag_valid || p != m_cur) begin
      exp_q.push_back({1'b1, tag_of(p)});
      m_tag_valid = 1'b1;
      m_cur       = p;
    end
    exp_q.push_back({1'b0, d});
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, (DB+1)'(exp_q.size()), '0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    chk(name, (DB+1)'(out_valid), (DB+1)'(1));
  endtask

  // Stream FIFO models: apply sampled pops, then present the new heads
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NB; i++) begin
      if (pop_mask[i] && sq[i].size() > 0) sq[i].delete(0);
      in_valid[i] = (sq[i].size() > 0);
      if (sq[i].size() > 0) begin
        in_data[i*DB +: DB]   = sq[i][0].d;
        in_period[i*PB +: PB] = sq[i][0].p;
      end else begin
        in_data[i*DB +: DB]   = '0;
        in_period[i*PB +: PB] = '0;
      end
    end
    pop_mask = '0;
  end

  always @(negedge clk) begin
    logic [DB:0] e;
    cyc++;
    if (!rst) begin
      if (in_ready != '0) begin
        chk("in_ready_onehot", (DB+1)'($countones(in_ready)), (DB+1)'(1));
        pop_mask = in_ready;
        for (int i = 0; i < NB; i++) if (in_ready[i]) glog.push_back(i);
      end
      if (out_valid && out_ready) begin
        xfer_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("sb_underflow", '0, (DB+1)'(1));
        end else begin
          e = exp_q.pop_front();
          chk("sb_packet", {out_is_tag, out_data}, e);
        end
      end
    end
  end

  initial begin
    int base;
    n_checks = 0; n_pass = 0; cyc = 0; pop_mask = '0;
    m_tag_valid = 1'b0; m_cur = '0;
    rst = 1'b1; enable = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", (DB+1)'(out_valid), '0);
    chk("rst_out_is_tag", (DB+1)'(out_is_tag), '0);
    chk("rst_out_data", (DB+1)'(out_data), '0);
    chk("rst_in_ready", (DB+1)'(in_ready), '0);
    rst = 1'b0;

    // First event after reset gets a tag even for period 0
    enable = 4'hF; out_ready = 1'b1;
    push(0, 48'd0, 128'hD0D0_0000_0000_0000_0000_0000_0000_00D0);
    exp_event(48'd0, 128'hD0D0_0000_0000_0000_0000_0000_0000_00D0);
    drain("t1_drain", 40);
    chk("t1_grant_count", (DB+1)'(glog.size()), (DB+1)'(1));
    chk("t1_grant_idx", (DB+1)'(glog[0]), '0);

    // Prime period 5 via stream 3, then all four streams compete
    push(3, 48'd5, 128'hA3);
    exp_event(48'd5, 128'hA3);
    drain("t2_prime", 40);
    glog.delete(); xfer_t.delete();
    push(0, 48'd5, 128'hB0); push(1, 48'd5, 128'hB1); push(2, 48'd5, 128'hB2);
    push(3, 48'd5, 128'hB3); push(0, 48'd5, 128'hB4);
    exp_event(48'd5, 128'hB0); exp_event(48'd5, 128'hB1); exp_event(48'd5, 128'hB2);
    exp_event(48'd5, 128'hB3); exp_event(48'd5, 128'hB4);
    drain("t2_drain", 60);
    chk("t2_grant_count", (DB+1)'(glog.size()), (DB+1)'(5));
    chk("t2_xfer_count", (DB+1)'(xfer_t.size()), (DB+1)'(5));
    if (glog.size() == 5) begin
      for (int k = 0; k < 5; k++) chk("t2_grant_order", (DB+1)'(glog[k]), (DB+1)'(k % 4));
    end
    if (xfer_t.size() == 5) begin
      for (int k = 1; k < 5; k++) chk("t2_throughput", (DB+1)'(xfer_t[k] - xfer_t[k-1]), (DB+1)'(2));
    end

    // Period change on a single stream: tag7, E, E, tag8, E
    glog.delete();
    push(1, 48'd7, 128'hC0); push(1, 48'd7, 128'hC1); push(1, 48'd8, 128'hC2);
    exp_event(48'd7, 128'hC0); exp_event(48'd7, 128'hC1); exp_event(48'd8, 128'hC2);
    drain("t3_drain", 60);
    chk("t3_grant_count", (DB+1)'(glog.size()), (DB+1)'(3));

    // Backpressure during a tag: output frozen, no further pops
    glog.delete();
    out_ready = 1'b0;
    push(2, 48'd9, 128'hE2);
    exp_event(48'd9, 128'hE2);
    wait_valid("t4_valid", 20);
    push(0, 48'd9, 128'hE0);
    exp_event(48'd9, 128'hE0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_hold_valid", (DB+1)'(out_valid), (DB+1)'(1));
      chk("t4_hold_is_tag", (DB+1)'(out_is_tag), (DB+1)'(1));
      chk("t4_hold_data", (DB+1)'(out_data), (DB+1)'(tag_of(48'd9)));
    end
    chk("t4_no_pops", (DB+1)'(glog.size()), (DB+1)'(1));
    out_ready = 1'b1;
    drain("t4_drain", 40);
    chk("t4_grant_count", (DB+1)'(glog.size()), (DB+1)'(2));
    if (glog.size() == 2) chk("t4_second_grant", (DB+1)'(glog[1]), '0);

    // Masked streams ignored; they are served once re-enabled
    glog.delete();
    enable = 4'b0101;
    for (int i = 0; i < NB; i++) begin
      push(i, 48'd9, 128'hF0 + 128'(i));
      push(i, 48'd9, 128'hF8 + 128'(i));
    end
    exp_event(48'd9, 128'hF2); exp_event(48'd9, 128'hF0);
    exp_event(48'd9, 128'hFA); exp_event(48'd9, 128'hF8);
    drain("t5_drain", 60);
    repeat (5) tick();
    chk("t5_grant_count", (DB+1)'(glog.size()), (DB+1)'(4));
    chk("t5_idle", (DB+1)'(out_valid), '0);
    if (glog.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("t5_grant_order", (DB+1)'(glog[k]), (k % 2 == 0) ? (DB+1)'(2) : '0);
    end
    enable = 4'hF;
    exp_event(48'd9, 128'hF1); exp_event(48'd9, 128'hF3);
    exp_event(48'd9, 128'hF9); exp_event(48'd9, 128'hFB);
    drain("t5_reenable_drain", 60);
    base = 4;
    if (glog.size() == 8) begin
      for (int k = 0; k < 4; k++) chk("t5_reenable_order", (DB+1)'(glog[base+k]), (k % 2 == 0) ? (DB+1)'(1) : (DB+1)'(3));
    end else begin
      chk("t5_reenable_count", (DB+1)'(glog.size()), (DB+1)'(8));
    end

    // Reset while an event is stalled: dropped, next event re-tagged
    out_ready = 1'b0;
    push(1, 48'd9, 128'h5A5A);
    exp_event(48'd9, 128'h5A5A);
    wait_valid("t6_valid", 20);
    chk("t6_event_state", {out_is_tag, out_data}, {1'b0, 128'h5A5A});
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", (DB+1)'(out_valid), '0);
    chk("t6_async_data", (DB+1)'(out_data), '0);
    chk("t6_async_in_ready", (DB+1)'(in_ready), '0);
    exp_q.delete();
    m_tag_valid = 1'b0; m_cur = '0;
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    push(1, 48'd9, 128'h7777);
    exp_event(48'd9, 128'h7777);
    drain("t6_drain", 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
